mastermind_round_sequencer: RTL
===============================

Name: mastermind_round_sequencer

Overview:
- Game-level controller for the Mastermind datapath: sequences secret-code entry, guess entry, the 4-cycle per-slot compare sweep, and guess counting.
- Detects win (4 red) and loss (guess limit reached), and restarts the game on request.
- Sits between the KEY/SW board inputs and the code/guess registers plus comparator.
- Replaces per-slot load states with a slot index and one write strobe per register bank.

Parameters:
- MAX_GUESSES, 8, guesses allowed per game (1..15).
- GC_W, 4, width of guess_count; must hold MAX_GUESSES.

Ports:
- clk  in  1  system clock
- resetn  in  1  reset; asynchronous assert, active-low
- load  in  1  level from pushbutton (already inverted), high while pressed
- red  in  3  red-peg count from comparator; valid in CHECK
- load_code  out  1  one-cycle write strobe into code field `slot`
- load_guess  out  1  one-cycle write strobe into guess field `slot`
- slot  out  2  field index for strobes (0 = bits 2:0 … 3 = bits 11:9)
- clear_score  out  1  one-cycle clear of comparator red/white/matched
- compare  out  1  comparator enable
- compare_i  out  2  code index under comparison
- score_valid  out  1  one-cycle pulse; red/white final for this guess
- guess_count  out  GC_W  completed guesses this game
- win  out  1  level, game won
- lose  out  1  level, game lost

Behaviour:
- Reset (async, resetn=0):
  - state=CODE_ARM; slot=0; compare_i=0; guess_count=0; load_q=0.
  - All strobes, win and lose = 0.
  - Release is synchronous to clk.
- Press detection:
  - load_q registers load each cycle.
  - press = load & ~load_q.
  - Holding load across any state never creates a press. The exception is load held through reset, which gives one press after release.
- States:
  - CODE_ARM: on press -> CODE_HOLD.
  - CODE_HOLD: while load=1, stay. In the cycle load=0, assert load_code (Mealy) with the current slot; the datapath samples data_in at that edge. If slot=3: slot<=0, go to GUESS_ARM. Else: slot<=slot+1, go to CODE_ARM.
  - GUESS_ARM / GUESS_HOLD: identical handshake using load_guess. After slot 3 is written, slot<=0 and go to CLEAR.
  - CLEAR: clear_score=1 for one cycle -> COMPARE with compare_i=0.
  - COMPARE: compare=1 for exactly 4 cycles, compare_i=0,1,2,3. After the compare_i=3 cycle -> CHECK.
  - CHECK (1 cycle): score_valid=1; guess_count<=guess_count+1 (saturate at MAX_GUESSES). If red==4 -> WIN. Else if guess_count+1==MAX_GUESSES -> LOSE. Else -> GUESS_ARM.
  - WIN / LOSE: win (or lose) held at 1. press -> RESTART.
  - RESTART: waits for load=0, then guess_count<=0, win/lose<=0, slot<=0 -> CODE_ARM.
- Latency:
  - From the 4th guess-slot release to score_valid: 6 cycles (CLEAR + 4 COMPARE + CHECK).
  - load is ignored from CLEAR through CHECK. A press during that window is not queued; the button must be re-pressed after GUESS_ARM is entered.
- Win takes priority over loss on the final guess: red==4 with guess_count+1==MAX_GUESSES -> WIN.
- Reset asserted mid-COMPARE or mid-HOLD aborts at once; no partial strobe is emitted after resetn falls.
- Invariants:
  - At most one of load_code, load_guess, clear_score, compare is high in any cycle.
  - slot is stable while any strobe is high.
- Illegal state encodings -> CODE_ARM on the next edge.

Decomposition:
- Package mastermind_pkg:
  - State enum (CODE_ARM, CODE_HOLD, GUESS_ARM, GUESS_HOLD, CLEAR, COMPARE, CHECK, WIN, LOSE, RESTART).
  - NUM_SLOTS=4, SLOT_W=2, PEG_W=3, RED_WIN=3'd4.
- One sub-module: mastermind_press_detect (load_q register; press and release outputs). Reused by future board controllers.

Test Plan:
1. Reset, then press/release load 4 times with data 1,2,3,4 -> load_code pulses with slot 0,1,2,3, each exactly 1 cycle, each in the cycle load falls; no load_guess pulse.
2. Code entered, then 4 guess presses -> load_guess slots 0..3. Then clear_score 1 cycle, then compare_i sequence 0,1,2,3 on 4 consecutive cycles, then score_valid 6 cycles after the last release; guess_count=1.
3. Model returns red=4 in CHECK -> win=1 the next cycle and stays; further presses hold win until release; then RESTART -> CODE_ARM with guess_count=0.
4. MAX_GUESSES=8, red=2 every guess -> lose=1 after the 8th CHECK; guess_count=8; no 9th guess strobes accepted.
5. Hold load high from CLEAR through CHECK -> no load_guess until load drops and is pressed again.
6. Assert resetn=0 on the 2nd COMPARE cycle -> compare drops without waiting for clk, all outputs 0; state restarts at CODE_ARM slot 0.

Source files
------------

// File: rtl/mastermind_round_sequencer_pkg.sv
// Shared types and constants for the Mastermind round sequencer and its
// board-side helpers.
package mastermind_pkg;

  localparam int NUM_SLOTS = 4;
  localparam int SLOT_W    = 2;
  localparam int PEG_W     = 3;
  localparam logic [PEG_W-1:0] RED_WIN = 3'd4;

  typedef enum logic [3:0] {
    CODE_ARM,
    CODE_HOLD,
    GUESS_ARM,
    GUESS_HOLD,
    CLEAR,
    COMPARE,
    CHECK,
    WIN,
    LOSE,
    RESTART
  } state_t;

endpackage

// File: rtl/mastermind_round_sequencer_if.sv
// Bundle between the round sequencer (master) and the board/datapath side
// (slave); state is carried along so checkers can observe the FSM.
interface mastermind_round_sequencer_if #(
  parameter int GC_W = 4
);
  import mastermind_pkg::*;

  // Strobes are single-cycle pulses sampled on the rising clock edge;
  // load is a debounced level and red is only meaningful while state is CHECK.
  logic              load;
  logic [PEG_W-1:0]  red;
  logic              load_code;
  logic              load_guess;
  logic [SLOT_W-1:0] slot;
  logic              clear_score;
  logic              compare;
  logic [SLOT_W-1:0] compare_i;
  logic              score_valid;
  logic [GC_W-1:0]   guess_count;
  logic              win;
  logic              lose;
  state_t            state;

  modport master (
    input  load, red,
    output load_code, load_guess, slot, clear_score, compare, compare_i,
           score_valid, guess_count, win, lose, state
  );

  modport slave (
    output load, red,
    input  load_code, load_guess, slot, clear_score, compare, compare_i,
           score_valid, guess_count, win, lose, state
  );

endinterface

// File: rtl/mastermind_press_detect.sv
// Edge detector for an already-debounced pushbutton level.
module mastermind_press_detect (
  input  logic clk,
  input  logic resetn,
  input  logic level,
  output logic press,
  output logic released
);

  logic level_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) level_q <= 1'b0;
    else         level_q <= level;
  end

  // level_q clears in reset, so a button held through reset reads as one press.
  assign press    = level & ~level_q;
  assign released = ~level & level_q;

endmodule

// File: rtl/mastermind_round_sequencer.sv
// Game-level sequencer: code entry, guess entry, 4-slot compare sweep,
// guess counting and win/lose detection.
module mastermind_round_sequencer
  import mastermind_pkg::*;
#(
  parameter int MAX_GUESSES = 8,
  parameter int GC_W        = 4
) (
  input  logic clk,
  input  logic resetn,
  mastermind_round_sequencer_if.master bus
);

  localparam logic [GC_W-1:0]   MAX_GC    = GC_W'(MAX_GUESSES);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_SLOTS - 1);

  state_t            state;
  logic [SLOT_W-1:0] slot;
  logic [SLOT_W-1:0] compare_i;
  logic [GC_W-1:0]   guess_count;
  logic              clear_score_q, compare_q, score_valid_q, win_q, lose_q;
  logic              press, released;
  logic [GC_W-1:0]   gc_inc;

  mastermind_press_detect u_press (
    .clk      (clk),
    .resetn   (resetn),
    .level    (bus.load),
    .press    (press),
    .released (released)
  );

  assign gc_inc = (guess_count == MAX_GC) ? MAX_GC : guess_count + GC_W'(1);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= CODE_ARM;
      slot          <= '0;
      compare_i     <= '0;
      guess_count   <= '0;
      clear_score_q <= 1'b0;
      compare_q     <= 1'b0;
      score_valid_q <= 1'b0;
      win_q         <= 1'b0;
      lose_q        <= 1'b0;
    end else begin
      clear_score_q <= 1'b0;
      score_valid_q <= 1'b0;
      case (state)
        CODE_ARM:  if (press) state <= CODE_HOLD;
        CODE_HOLD: if (released) begin
          if (slot == LAST_SLOT) begin
            slot  <= '0;
            state <= GUESS_ARM;
          end else begin
            slot  <= slot + SLOT_W'(1);
            state <= CODE_ARM;
          end
        end
        GUESS_ARM:  if (press) state <= GUESS_HOLD;
        GUESS_HOLD: if (released) begin
          if (slot == LAST_SLOT) begin
            slot          <= '0;
            clear_score_q <= 1'b1;
            state         <= CLEAR;
          end else begin
            slot  <= slot + SLOT_W'(1);
            state <= GUESS_ARM;
          end
        end
        CLEAR: begin
          compare_q <= 1'b1;
          compare_i <= '0;
          state     <= COMPARE;
        end
        COMPARE: begin
          if (compare_i == LAST_SLOT) begin
            compare_q     <= 1'b0;
            compare_i     <= '0;
            score_valid_q <= 1'b1;
            state         <= CHECK;
          end else begin
            compare_i <= compare_i + SLOT_W'(1);
          end
        end
        CHECK: begin
          guess_count <= gc_inc;
          // A full match on the final guess still counts as a win.
          if (bus.red == RED_WIN) begin
            win_q <= 1'b1;
            state <= WIN;
          end else if (gc_inc == MAX_GC) begin
            lose_q <= 1'b1;
            state  <= LOSE;
          end else begin
            state <= GUESS_ARM;
          end
        end
        WIN, LOSE: if (press) state <= RESTART;
        RESTART: if (!bus.load) begin
          guess_count <= '0;
          win_q       <= 1'b0;
          lose_q      <= 1'b0;
          slot        <= '0;
          state       <= CODE_ARM;
        end
        default: begin
          state     <= CODE_ARM;
          slot      <= '0;
          compare_i <= '0;
          compare_q <= 1'b0;
        end
      endcase
    end
  end

  // Write strobes are Mealy so the register bank samples in the release cycle.
  assign bus.load_code   = (state == CODE_HOLD)  && released;
  assign bus.load_guess  = (state == GUESS_HOLD) && released;
  assign bus.slot        = slot;
  assign bus.clear_score = clear_score_q;
  assign bus.compare     = compare_q;
  assign bus.compare_i   = compare_i;
  assign bus.score_valid = score_valid_q;
  assign bus.guess_count = guess_count;
  assign bus.win         = win_q;
  assign bus.lose        = lose_q;
  assign bus.state       = state;

endmodule
